// File: rtl/complex_pkg.sv
// complex_pkg
//   Shared constants and types for the complex multiplier datapath.
//   DATA_W      : operand component width (signed)
//   OUT_W       : result component width (signed), 2*DATA_W
//   SUM_W       : width at which sums/differences of products are formed
//   OUT_MAX/MIN : saturation bounds of an OUT_W signed result
package complex_pkg;

    localparam int DATA_W = 8;
    localparam int OUT_W  = 2 * DATA_W;
    localparam int SUM_W  = 2 * DATA_W + 1;

    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_in_t;

    typedef struct packed {
        logic signed [OUT_W-1:0] re;
        logic signed [OUT_W-1:0] im;
    } cplx_out_t;

endpackage

// File: rtl/cplx_sat_add.sv
// cplx_sat_add
//   Combinational signed add/subtract of two SUM_W operands, saturated to OUT_W.
//   a_i   : signed SUM_W left operand
//   b_i   : signed SUM_W right operand
//   sub_i : 1 = a_i - b_i, 0 = a_i + b_i
//   y_o   : signed OUT_W saturated result
module cplx_sat_add
    import complex_pkg::*;
(
    input  logic signed [SUM_W-1:0] a_i,
    input  logic signed [SUM_W-1:0] b_i,
    input  logic                    sub_i,
    output logic signed [OUT_W-1:0] y_o
);

    logic signed [SUM_W-1:0] sum;

    // Operands are sign-extended OUT_W products, so the SUM_W result never wraps.
    always_comb begin
        sum = sub_i ? (a_i - b_i) : (a_i + b_i);
        if (sum > SUM_W'(OUT_MAX)) begin
            y_o = OUT_MAX;
        end else if (sum < SUM_W'(OUT_MIN)) begin
            y_o = OUT_MIN;
        end else begin
            y_o = sum[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/complex_multiplier.sv
// complex_multiplier
//   Two-stage pipelined signed complex multiply z = a * b with held outputs.
//   Stage 1 registers the four partial products, stage 2 registers the
//   saturated real/imag sums. Latency 2, throughput 1 per cycle, no stall.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   a_real/imag: signed operand a
//   b_real/imag: signed operand b
//   data_valid : bit0 qualifies operands; bit1 is reserved and ignored
//   z_real/imag: signed result, held until the next valid result
//   z_valid    : one-cycle pulse when z_real/z_imag update
module complex_multiplier
    import complex_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] a_real,
    input  logic signed [DATA_W-1:0] a_imag,
    input  logic signed [DATA_W-1:0] b_real,
    input  logic signed [DATA_W-1:0] b_imag,
    input  logic [1:0]               data_valid,
    output logic signed [OUT_W-1:0]  z_real,
    output logic signed [OUT_W-1:0]  z_imag,
    output logic                     z_valid
);

    cplx_in_t  a_op, b_op;
    cplx_out_t z_d, z_q;

    logic signed [OUT_W-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
    logic signed [OUT_W-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic                    s1_vld_q, z_vld_q;
    logic signed [OUT_W-1:0] sum_re, sum_im;
    logic                    dv_rsvd_unused;

    assign dv_rsvd_unused = data_valid[1];

    assign a_op = '{re: a_real, im: a_imag};
    assign b_op = '{re: b_real, im: b_imag};

    // Widen first so each product is a full OUT_W signed multiply.
    always_comb begin
        p_rr_d = OUT_W'(a_op.re) * OUT_W'(b_op.re);
        p_ii_d = OUT_W'(a_op.im) * OUT_W'(b_op.im);
        p_ri_d = OUT_W'(a_op.re) * OUT_W'(b_op.im);
        p_ir_d = OUT_W'(a_op.im) * OUT_W'(b_op.re);
    end

    // Stage 1: products only load on a valid strobe; the flag tracks the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_rr_q   <= '0;
            p_ii_q   <= '0;
            p_ri_q   <= '0;
            p_ir_q   <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= data_valid[0];
            if (data_valid[0]) begin
                p_rr_q <= p_rr_d;
                p_ii_q <= p_ii_d;
                p_ri_q <= p_ri_d;
                p_ir_q <= p_ir_d;
            end
        end
    end

    cplx_sat_add u_sat_re (
        .a_i   (SUM_W'(p_rr_q)),
        .b_i   (SUM_W'(p_ii_q)),
        .sub_i (1'b1),
        .y_o   (sum_re)
    );

    cplx_sat_add u_sat_im (
        .a_i   (SUM_W'(p_ri_q)),
        .b_i   (SUM_W'(p_ir_q)),
        .sub_i (1'b0),
        .y_o   (sum_im)
    );

    assign z_d = '{re: sum_re, im: sum_im};

    // Stage 2: outputs hold between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q     <= '0;
            z_vld_q <= 1'b0;
        end else begin
            z_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                z_q <= z_d;
            end
        end
    end

    assign z_real  = z_q.re;
    assign z_imag  = z_q.im;
    assign z_valid = z_vld_q;

endmodule

// File: tb/tb_complex_multiplier.sv
module tb_complex_multiplier;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [7:0]  a_real = '0, a_imag = '0, b_real = '0, b_imag = '0;
    logic [1:0]         data_valid = 2'b00;
    logic signed [15:0] z_real, z_imag;
    logic               z_valid;

    typedef struct {
        int re;
        int im;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_re = 0;
    int   last_im = 0;

    complex_multiplier dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_real     (a_real),
        .a_imag     (a_imag),
        .b_real     (b_real),
        .b_imag     (b_imag),
        .data_valid (data_valid),
        .z_real     (z_real),
        .z_imag     (z_imag),
        .z_valid    (z_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (z_valid) begin
            if (q.size() == 0) begin
                chk("spurious_vld", 1, 0);
            end else begin
                e = q.pop_front();
                chk("z_re", int'(z_real), e.re);
                chk("z_im", int'(z_imag), e.im);
                chk("latency", cyc, e.cyc);
                last_re = e.re;
                last_im = e.im;
            end
        end else begin
            chk("hold_re", int'(z_real), last_re);
            chk("hold_im", int'(z_imag), last_im);
        end
    end

    // Called just after a rising edge; operands sample on the next edge.
    task automatic send(input int ar, input int ai, input int br, input int bi);
        exp_t e;
        a_real = 8'(ar);
        a_imag = 8'(ai);
        b_real = 8'(br);
        b_imag = 8'(bi);
        data_valid = 2'b01;
        e.re  = clamp16(ar * br - ai * bi);
        e.im  = clamp16(ar * bi + ai * br);
        e.cyc = cyc + 2;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Idle cycles with junk operands; sometimes only the reserved bit is set.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            a_real = 8'($urandom);
            a_imag = 8'($urandom);
            b_real = 8'($urandom);
            b_imag = 8'($urandom);
            data_valid = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
            @(posedge clk);
            #1;
        end
        data_valid = 2'b00;
    endtask

    initial begin
        #2;
        chk("rst_re", int'(z_real), 0);
        chk("rst_im", int'(z_imag), 0);
        chk("rst_vld", int'(z_valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Single pulse, then long hold
        send(1, 2, 3, 4);
        idle(22);

        // Spaced operand sets
        send(2, 4, 6, 8);
        idle(2);
        send(1, 3, 5, 7);
        idle(2);
        send(1, 2, 1, 2);
        idle(4);

        // Back-to-back
        send(1, 2, 3, 4);
        send(2, 4, 6, 8);
        send(1, 3, 5, 7);
        idle(4);

        // Extremes, including the single saturating case
        send(-128, -128, -128, -128);
        send(127, 127, 127, -128);
        idle(4);

        // Reset one cycle after a valid: in-flight result discarded
        send(5, 6, 7, 8);
        rst_n = 1'b0;
        q.delete();
        last_re = 0;
        last_im = 0;
        #1;
        chk("arst_re", int'(z_real), 0);
        chk("arst_im", int'(z_imag), 0);
        chk("arst_vld", int'(z_valid), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
        send(1, 2, 3, 4);
        idle(4);

        // Random mix of valid and idle cycles
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0)
                send($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                     $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
            else
                idle(1);
        end
        idle(5);

        chk("drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
